// File: rtl/bus_clk_pkg.sv
// bus_clk_pkg
// Shared definitions for the bus clock controller:
//   - rate codes carried on ReqRate/CurRate
//   - controller FSM state encoding
//   - divider lookups (rate code -> period length N, and last phase N-1)
// Imported by bus_clk_phase and bus_clk_ctrl.
package bus_clk_pkg;

  localparam logic [1:0] RATE_20M  = 2'd0;  // ClkIn / 2
  localparam logic [1:0] RATE_10M  = 2'd1;  // ClkIn / 4
  localparam logic [1:0] RATE_5M   = 2'd2;  // ClkIn / 8
  localparam logic [1:0] RATE_STOP = 2'd3;  // BusClk held low

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_QUIET   = 2'd3
  } state_e;

  // Period length in ClkIn cycles; 0 marks the stopped rate.
  function automatic logic [3:0] rate_div(input logic [1:0] rate);
    case (rate)
      RATE_20M: rate_div = 4'd2;
      RATE_10M: rate_div = 4'd4;
      RATE_5M:  rate_div = 4'd8;
      default:  rate_div = 4'd0;
    endcase
  endfunction

  // Phase value of the last cycle of a period; the stopped rate sits at 0.
  function automatic logic [2:0] rate_last_phase(input logic [1:0] rate);
    logic [3:0] n;
    n = rate_div(rate);
    if (n == 4'd0) begin
      rate_last_phase = 3'd0;
    end else begin
      rate_last_phase = 3'(n - 4'd1);
    end
  endfunction

endpackage

// File: rtl/bus_clk_phase.sv
// bus_clk_phase
// Phase counter of the bus clock divider plus registered BusClk/BusClkEn.
// The controller hands in its next-cycle intent, so the registered outputs
// always describe the phase/rate/state that are current in the same cycle.
// Ports:
//   ClkIn, nRst   clock, asynchronous active-low reset
//   clr_i         force phase to 0 next cycle (period restart)
//   adv_i         advance phase by one (wraps at N-1)
//   en_i          bus clock is driven next cycle (RUN or DRAIN)
//   rate_i        rate code in force next cycle
//   phase_o       current phase
//   BusClk_o      high while phase < N/2
//   BusClkEn_o    high when phase == 0
module bus_clk_phase
  import bus_clk_pkg::*;
(
  input  logic       ClkIn,
  input  logic       nRst,
  input  logic       clr_i,
  input  logic       adv_i,
  input  logic       en_i,
  input  logic [1:0] rate_i,
  output logic [2:0] phase_o,
  output logic       BusClk_o,
  output logic       BusClkEn_o
);

  logic [2:0] phase_q, phase_d;
  logic [3:0] half_s;
  logic       stop_s;
  logic       bus_clk_q, bus_clk_d;
  logic       bus_en_q, bus_en_d;

  // Next phase and the bus clock levels that phase implies.
  always_comb begin
    stop_s  = (rate_i == RATE_STOP);
    half_s  = rate_div(rate_i) >> 3'd1;
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = 3'd0;
    end else if (adv_i) begin
      if (stop_s || (phase_q == rate_last_phase(rate_i))) begin
        phase_d = 3'd0;
      end else begin
        phase_d = phase_q + 3'd1;
      end
    end else begin
      phase_d = phase_q;
    end
    bus_clk_d = en_i && !stop_s && ({1'b0, phase_d} < half_s);
    bus_en_d  = en_i && !stop_s && (phase_d == 3'd0);
  end

  // Phase and bus clock registers.
  always_ff @(posedge ClkIn or negedge nRst) begin
    if (!nRst) begin
      phase_q   <= 3'd0;
      bus_clk_q <= 1'b0;
      bus_en_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      bus_clk_q <= bus_clk_d;
      bus_en_q  <= bus_en_d;
    end
  end

  assign phase_o    = phase_q;
  assign BusClk_o   = bus_clk_q;
  assign BusClkEn_o = bus_en_q;

endmodule

// File: rtl/bus_clk_ctrl.sv
// bus_clk_ctrl
// Glitch-free bus clock rate controller. After STARTUP_CYCLES it runs the
// bus clock at CurRate; a rate change drains the old period to its end,
// holds BusClk low for QUIET_CYCLES, then restarts at phase 0 of the new
// rate. All outputs are registers.
// Ports:
//   ClkIn, nRst          clock, asynchronous active-low reset
//   ReqValid/ReqRate     rate-change request (0=div2, 1=div4, 2=div8, 3=stop)
//   ReqReady             request accepted on ReqValid && ReqReady
//   RateDone             one-cycle pulse when the requested rate is active
//   CurRate              rate driven on BusClk
//   BusClk, BusClkEn     bus clock and its rising-edge strobe
//   ClkEn20, ClkEn10     free-running 20/10 MHz clock enables
//   Locked               startup complete
//   SwitchCnt[7:0]       saturating count of real rate changes
//                        (only when BUS_CLK_SWCNT_EN is defined)
module bus_clk_ctrl
  import bus_clk_pkg::*;
#(
  parameter int         STARTUP_CYCLES = 16,
  parameter int         QUIET_CYCLES   = 2,
  parameter logic [1:0] DEFAULT_RATE   = 2'd1
) (
  input  logic       ClkIn,
  input  logic       nRst,
  input  logic       ReqValid,
  input  logic [1:0] ReqRate,
  output logic       ReqReady,
  output logic       RateDone,
  output logic [1:0] CurRate,
  output logic       BusClk,
  output logic       BusClkEn,
  output logic       ClkEn20,
  output logic       ClkEn10,
  output logic       Locked
`ifdef BUS_CLK_SWCNT_EN
  ,
  output logic [7:0] SwitchCnt
`endif
);

  state_e     state_q, state_d;
  logic [7:0] scnt_q, scnt_d;
  logic [3:0] qcnt_q, qcnt_d;
  logic [1:0] rate_q, rate_d;
  logic [1:0] pend_q, pend_d;
  logic       locked_q, locked_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic [1:0] cnt_q, cnt_d;
  logic       en20_q, en10_q;
  logic       clr_s, adv_s, en_s, last_s, accept_s;
  logic [2:0] phase_s;

  assign cnt_d    = cnt_q + 2'd1;
  assign accept_s = ReqValid && (state_q == ST_RUN);
  // Stopped rate has no period, so every cycle counts as a period end.
  assign last_s   = (rate_q == RATE_STOP) || (phase_s == rate_last_phase(rate_q));
  assign en_s     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  assign ready_d  = (state_d == ST_RUN);

  // Controller next-state logic.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    qcnt_d   = qcnt_q;
    rate_d   = rate_q;
    pend_d   = pend_q;
    locked_d = locked_q;
    done_d   = 1'b0;
    clr_s    = 1'b0;
    adv_s    = 1'b0;
    case (state_q)
      ST_STARTUP: begin
        if (scnt_q == 8'(STARTUP_CYCLES - 1)) begin
          state_d  = ST_RUN;
          clr_s    = 1'b1;
          locked_d = 1'b1;
        end else begin
          scnt_d = scnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        adv_s = 1'b1;
        if (accept_s) begin
          if (ReqRate == rate_q) begin
            done_d = 1'b1;
          end else begin
            pend_d = ReqRate;
            // Already at the end of a period: no draining needed.
            if (last_s) begin
              state_d = ST_QUIET;
              qcnt_d  = 4'd0;
              clr_s   = 1'b1;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end else begin
          done_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (last_s) begin
          state_d = ST_QUIET;
          qcnt_d  = 4'd0;
          clr_s   = 1'b1;
        end else begin
          adv_s = 1'b1;
        end
      end
      ST_QUIET: begin
        if (qcnt_q == 4'(QUIET_CYCLES - 1)) begin
          state_d = ST_RUN;
          clr_s   = 1'b1;
          rate_d  = pend_q;
          done_d  = 1'b1;
        end else begin
          qcnt_d = qcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_STARTUP;
      end
    endcase
  end

  // Controller state and registered status outputs.
  always_ff @(posedge ClkIn or negedge nRst) begin
    if (!nRst) begin
      state_q  <= ST_STARTUP;
      scnt_q   <= 8'd0;
      qcnt_q   <= 4'd0;
      rate_q   <= DEFAULT_RATE;
      pend_q   <= DEFAULT_RATE;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      cnt_q    <= 2'd0;
      en20_q   <= 1'b0;
      en10_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      qcnt_q   <= qcnt_d;
      rate_q   <= rate_d;
      pend_q   <= pend_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      en20_q   <= cnt_d[0];
      en10_q   <= (cnt_d == 2'd3);
    end
  end

  bus_clk_phase u_phase (
    .ClkIn      (ClkIn),
    .nRst       (nRst),
    .clr_i      (clr_s),
    .adv_i      (adv_s),
    .en_i       (en_s),
    .rate_i     (rate_d),
    .phase_o    (phase_s),
    .BusClk_o   (BusClk),
    .BusClkEn_o (BusClkEn)
  );

`ifdef BUS_CLK_SWCNT_EN
  logic [7:0] swcnt_q;
  logic       sw_inc_s;

  // Leaving QUIET always completes a real rate change.
  assign sw_inc_s = (state_q == ST_QUIET) && (state_d == ST_RUN);

  // Saturating rate-change counter.
  always_ff @(posedge ClkIn or negedge nRst) begin
    if (!nRst) begin
      swcnt_q <= 8'd0;
    end else if (sw_inc_s && (swcnt_q != 8'd255)) begin
      swcnt_q <= swcnt_q + 8'd1;
    end else begin
      swcnt_q <= swcnt_q;
    end
  end

  assign SwitchCnt = swcnt_q;
`endif

  assign ReqReady = ready_q;
  assign RateDone = done_q;
  assign CurRate  = rate_q;
  assign ClkEn20  = en20_q;
  assign ClkEn10  = en10_q;
  assign Locked   = locked_q;

endmodule

// File: tb/tb_bus_clk_ctrl.sv
// tb_bus_clk_ctrl
// Directed bench for bus_clk_ctrl with default parameters. A cycle-level
// model built from countdowns (cycles since reset, position in the current
// period, cycles left until the new rate starts) is compared against every
// output on every falling edge; literal waveform snippets pin the model.
// Define BUS_CLK_SWCNT_EN to also exercise SwitchCnt.
module tb_bus_clk_ctrl;

  localparam int SC = 16;
  localparam int QC = 2;

  logic       ClkIn = 1'b0;
  logic       nRst = 1'b1;
  logic       ReqValid = 1'b0;
  logic [1:0] ReqRate = 2'd0;
  logic       ReqReady, RateDone, BusClk, BusClkEn, ClkEn20, ClkEn10, Locked;
  logic [1:0] CurRate;
`ifdef BUS_CLK_SWCNT_EN
  logic [7:0] SwitchCnt;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 ClkIn = ~ClkIn;

  bus_clk_ctrl dut (
    .ClkIn    (ClkIn),
    .nRst     (nRst),
    .ReqValid (ReqValid),
    .ReqRate  (ReqRate),
    .ReqReady (ReqReady),
    .RateDone (RateDone),
    .CurRate  (CurRate),
    .BusClk   (BusClk),
    .BusClkEn (BusClkEn),
    .ClkEn20  (ClkEn20),
    .ClkEn10  (ClkEn10),
    .Locked   (Locked)
`ifdef BUS_CLK_SWCNT_EN
    ,
    .SwitchCnt(SwitchCnt)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int div_n(input logic [1:0] r);
    case (r)
      2'd0: return 2;
      2'd1: return 4;
      2'd2: return 8;
      default: return 1;
    endcase
  endfunction

  // Model: m_busy counts cycles until the new rate starts; while it is
  // above QC the old rate keeps running, otherwise the bus clock is quiet.
  int         m_cyc = 0;
  int         m_pos = 0;
  int         m_busy = 0;
  int         m_swcnt = 0;
  bit         m_locked = 1'b0;
  bit         m_done = 1'b0;
  logic [1:0] m_rate = 2'd1;
  logic [1:0] m_pend = 2'd1;

  always @(posedge ClkIn or negedge nRst) begin
    if (!nRst) begin
      m_cyc <= 0; m_pos <= 0; m_busy <= 0; m_swcnt <= 0;
      m_locked <= 1'b0; m_done <= 1'b0; m_rate <= 2'd1; m_pend <= 2'd1;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_done <= 1'b0;
      if (!m_locked) begin
        if (m_cyc + 1 == SC) begin
          m_locked <= 1'b1;
          m_pos    <= 0;
        end
      end else if (m_busy == 0) begin
        if (ReqValid && ReqRate == m_rate) m_done <= 1'b1;
        if (ReqValid && ReqRate != m_rate) begin
          m_pend <= ReqRate;
          m_busy <= ((m_rate == 2'd3) ? 0 : div_n(m_rate) - 1 - m_pos) + QC;
        end
        if (m_rate != 2'd3) m_pos <= (m_pos + 1) % div_n(m_rate);
      end else begin
        if (m_busy > QC) m_pos <= (m_pos + 1) % div_n(m_rate);
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_rate <= m_pend;
          m_pos  <= 0;
          m_done <= 1'b1;
          if (m_swcnt < 255) m_swcnt <= m_swcnt + 1;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge ClkIn) begin
    bit active, e_bc, e_en;
    if (chk_en) begin
      active = m_locked && (m_busy == 0 || m_busy > QC) && (m_rate != 2'd3);
      e_bc   = active && (m_pos < div_n(m_rate) / 2);
      e_en   = active && (m_pos == 0);
      check("BusClk", int'(BusClk), int'(e_bc));
      check("BusClkEn", int'(BusClkEn), int'(e_en));
      check("ClkEn20", int'(ClkEn20), int'(m_cyc % 2 == 1));
      check("ClkEn10", int'(ClkEn10), int'(m_cyc % 4 == 3));
      check("Locked", int'(Locked), int'(m_locked));
      check("ReqReady", int'(ReqReady), int'(m_locked && m_busy == 0));
      check("RateDone", int'(RateDone), int'(m_done));
      check("CurRate", int'(CurRate), int'(m_rate));
`ifdef BUS_CLK_SWCNT_EN
      check("SwitchCnt", int'(SwitchCnt), m_swcnt);
`endif
    end
  end

  // Count falling edges until Locked rises (bounded).
  task automatic wait_locked(output int k);
    k = 0;
    while (!Locked && k < 40) begin
      @(negedge ClkIn);
      k++;
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!ReqReady && t < 100) begin
      @(negedge ClkIn);
      t++;
    end
    if (t >= 100) check("ready_timeout", t, 0);
  endtask

  // Optionally issue a one-cycle request, then record n cycles of outputs,
  // first cycle in the highest recorded bit (time reads left to right).
  task automatic run_seq(input bit do_req, input logic [1:0] rate, input int n,
                         output logic [15:0] bc, output logic [15:0] en,
                         output logic [15:0] rd);
    bc = 16'd0; en = 16'd0; rd = 16'd0;
    ReqValid = do_req;
    ReqRate  = rate;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge ClkIn);
        ReqValid = 1'b0;
      end
      bc = {bc[14:0], BusClk};
      en = {en[14:0], BusClkEn};
      rd = {rd[14:0], RateDone};
    end
  endtask

  initial begin
    int k;
    logic [15:0] bc, en, rd;
    #1 nRst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge ClkIn);
    check("rst_CurRate", int'(CurRate), 1);
    check("rst_Locked", int'(Locked), 0);
    nRst = 1'b1;

    // Startup and default-rate waveform.
    wait_locked(k);
    check("lock_latency", k, 16);
    check("ClkEn20_first_run", int'(ClkEn20), 0);
    run_seq(1'b0, 2'd0, 8, bc, en, rd);
    check("run10_BusClk", int'(bc), 16'b11001100);
    check("run10_BusClkEn", int'(en), 16'b10001000);

    // Same-rate request at phase 3: pattern continues, RateDone next cycle.
    run_seq(1'b1, 2'd1, 6, bc, en, rd);
    check("same_BusClk", int'(bc), 16'b011001);
    check("same_RateDone", int'(rd), 16'b010000);

    // Rate 1 -> 0 accepted at phase 1.
    @(negedge ClkIn);
    run_seq(1'b1, 2'd0, 9, bc, en, rd);
    check("r1to0_BusClk", int'(bc), 16'b100001010);
    check("r1to0_RateDone", int'(rd), 16'b000001000);
    check("r1to0_CurRate", int'(CurRate), 0);

    // Stop the clock, then restart at rate 2.
    run_seq(1'b1, 2'd3, 6, bc, en, rd);
    check("stop_BusClk", int'(bc), 16'b000000);
    check("stop_RateDone", int'(rd), 16'b000100);
    check("stop_CurRate", int'(CurRate), 3);
    run_seq(1'b1, 2'd2, 12, bc, en, rd);
    check("r3to2_BusClk", int'(bc), 16'b000111100001);
    check("r3to2_BusClkEn", int'(en), 16'b000100000001);
    check("r3to2_RateDone", int'(rd), 16'b000100000000);

    // Reset asserted while QUIET.
    ReqValid = 1'b1; ReqRate = 2'd0;
    @(negedge ClkIn);
    ReqValid = 1'b0;
    repeat (7) @(negedge ClkIn);
    check("quiet_ReqReady", int'(ReqReady), 0);
    #2 nRst = 1'b0;
    #1;
    check("async_BusClk", int'(BusClk), 0);
    check("async_BusClkEn", int'(BusClkEn), 0);
    check("async_Locked", int'(Locked), 0);
    check("async_ReqReady", int'(ReqReady), 0);
    check("async_RateDone", int'(RateDone), 0);
    check("async_CurRate", int'(CurRate), 1);
    check("async_ClkEn", int'({ClkEn20, ClkEn10}), 0);
    repeat (2) @(negedge ClkIn);
    nRst = 1'b1;
    wait_locked(k);
    check("relock_latency", k, 16);

    // Requests while not ready are ignored; only the accepted rate lands.
    ReqValid = 1'b1; ReqRate = 2'd2;
    @(negedge ClkIn);
    ReqRate = 2'd0;
    repeat (4) @(negedge ClkIn);
    ReqValid = 1'b0;
    repeat (3) @(negedge ClkIn);
    check("ignored_CurRate", int'(CurRate), 2);

`ifdef BUS_CLK_SWCNT_EN
    // 300 real switches plus same-rate requests that must not count.
    for (int i = 0; i < 300; i++) begin
      wait_ready();
      if (i % 10 == 0) begin
        ReqValid = 1'b1; ReqRate = m_rate;
        @(negedge ClkIn);
      end
      ReqValid = 1'b1;
      ReqRate  = (m_rate == 2'd0) ? 2'd1 : 2'd0;
      @(negedge ClkIn);
      ReqValid = 1'b0;
    end
    wait_ready();
    check("SwitchCnt_sat", int'(SwitchCnt), 255);
`endif

    ReqValid = 1'b0;
    repeat (4) @(negedge ClkIn);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
